// File: rtl/branch_ctrl_pkg.sv
// Shared defines for the branch path: branch op codes, branch-controller
// state encoding and redirect drain defaults.
package branch_ctrl_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6
    } br_op_t;

    typedef enum logic [1:0] {
        BC_IDLE     = 2'd0,
        BC_RESOLVE  = 2'd1,
        BC_REDIRECT = 2'd2,
        BC_DRAIN    = 2'd3
    } bc_state_t;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;

    function automatic logic tgt_misaligned(input logic [31:0] tgt);
        return tgt[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/branch_ctrl.sv
// Branch controller: issues one branch to the shared branch unit, reports
// the resolution and sequences the fetch redirect plus drain stall.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  br_op_t      req_br_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_imm_b,
    input  logic [31:0] req_pc,
    output br_op_t      bru_op,
    output logic [31:0] bru_rs1,
    output logic [31:0] bru_rs2,
    output logic [31:0] bru_imm_b,
    output logic [31:0] bru_pc,
    input  logic        bru_taken,
    input  logic [31:0] bru_target,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        stall,
    output logic        res_valid,
    output logic        res_taken,
    output logic        misalign,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);

    localparam logic [3:0] DRAIN_LOAD = 4'(FLUSH_CYCLES - 1);

    bc_state_t   state;
    br_op_t      op_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] pc_q;
    logic [3:0]  drain_cnt;
    logic        resolve;
    logic        tgt_bad;

    // Outputs are gated by rst_n so nothing leaks while reset is held.
    assign resolve = rst_n && (state == BC_RESOLVE);
    assign tgt_bad = tgt_misaligned(bru_target);

    assign req_ready   = !rst_n || (state == BC_IDLE);
    assign bru_op      = (!rst_n || state == BC_IDLE) ? BR_NONE : op_q;
    assign bru_rs1     = rs1_q;
    assign bru_rs2     = rs2_q;
    assign bru_imm_b   = imm_q;
    assign bru_pc      = pc_q;
    assign res_valid   = resolve;
    assign res_taken   = resolve && bru_taken;
    assign misalign    = resolve && bru_taken && tgt_bad;
    assign flush       = resolve && bru_taken && !tgt_bad;
    assign redir_valid = rst_n && (state == BC_REDIRECT);
    assign stall       = rst_n && (state == BC_REDIRECT || state == BC_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BC_IDLE;
            op_q        <= BR_NONE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            redir_pc    <= '0;
            drain_cnt   <= '0;
            br_count    <= '0;
            taken_count <= '0;
        end else begin
            case (state)
                BC_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_br_op;
                        rs1_q <= req_rs1;
                        rs2_q <= req_rs2;
                        imm_q <= req_imm_b;
                        pc_q  <= req_pc;
                        state <= BC_RESOLVE;
                    end
                end
                BC_RESOLVE: begin
                    br_count <= br_count + 32'd1;
                    if (bru_taken) begin
                        taken_count <= taken_count + 32'd1;
                    end
                    if (bru_taken && !tgt_bad) begin
                        redir_pc <= bru_target;
                        state    <= BC_REDIRECT;
                    end else begin
                        state <= BC_IDLE;
                    end
                end
                BC_REDIRECT: begin
                    if (redir_ready) begin
                        drain_cnt <= DRAIN_LOAD;
                        state     <= BC_DRAIN;
                    end
                end
                BC_DRAIN: begin
                    if (drain_cnt == 4'd0) begin
                        state <= BC_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: state <= BC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: random and directed branches against a
// behavioural branch model, with an external branch unit model.
module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    br_op_t      req_br_op = BR_NONE;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [31:0] req_imm_b = '0;
    logic [31:0] req_pc = '0;
    br_op_t      bru_op;
    logic [31:0] bru_rs1, bru_rs2, bru_imm_b, bru_pc;
    logic        bru_taken;
    logic [31:0] bru_target;
    logic        redir_valid;
    logic        redir_ready = 1'b0;
    logic [31:0] redir_pc;
    logic        flush, stall, res_valid, res_taken, misalign;
    logic [31:0] br_count, taken_count;

    always #5 clk = ~clk;

    branch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_br_op(req_br_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm_b(req_imm_b), .req_pc(req_pc),
        .bru_op(bru_op), .bru_rs1(bru_rs1), .bru_rs2(bru_rs2),
        .bru_imm_b(bru_imm_b), .bru_pc(bru_pc),
        .bru_taken(bru_taken), .bru_target(bru_target),
        .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_pc(redir_pc), .flush(flush), .stall(stall),
        .res_valid(res_valid), .res_taken(res_taken), .misalign(misalign),
        .br_count(br_count), .taken_count(taken_count)
    );

    function automatic logic cond(input br_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return $signed(a) < $signed(b);
            BR_BGE:  return $signed(a) >= $signed(b);
            BR_BLTU: return a < b;
            BR_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Shared branch unit sitting outside the controller.
    always_comb begin
        bru_taken  = cond(bru_op, bru_rs1, bru_rs2);
        bru_target = bru_pc + bru_imm_b;
    end

    typedef struct {
        logic        taken;
        logic        mis;
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] brc;
        logic [31:0] tkc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_br = '0;
    logic [31:0] m_tk = '0;
    int          hold_lo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Fetch side: hold redir_ready low for hold_lo cycles, random otherwise.
    int wcnt = 0;
    always @(posedge clk) begin
        #1;
        if (redir_valid) begin
            if (wcnt < hold_lo) begin
                redir_ready = 1'b0;
                wcnt++;
            end else begin
                redir_ready = 1'b1;
            end
        end else begin
            wcnt = 0;
            redir_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor
    logic        redir_exp = 1'b0;
    logic [31:0] redir_tgt = '0;
    int          post = -1;
    logic        after_res = 1'b0;
    exp_t        last;

    always @(negedge clk) begin
        if (!rst_n) begin
            redir_exp = 1'b0;
            post = -1;
            after_res = 1'b0;
            q.delete();
        end else begin
            if (after_res) begin
                after_res = 1'b0;
                chk("br_count", br_count, last.brc);
                chk("taken_count", taken_count, last.tkc);
                if (!last.redir) begin
                    chk("ready_after_res", 32'({stall, req_ready}), 32'd1);
                end
            end
            if (post >= 0) begin
                post++;
                if (post <= FC) begin
                    chk("drain_stall", 32'({stall, req_ready}), 32'd2);
                end else begin
                    chk("drain_end", 32'({stall, req_ready}), 32'd1);
                    post = -1;
                end
            end
            if (res_valid) begin
                if (q.size() == 0) begin
                    bad("unexpected_res_valid");
                end else begin
                    last = q.pop_front();
                    chk("res_taken", 32'(res_taken), 32'(last.taken));
                    chk("misalign", 32'(misalign), 32'(last.mis));
                    chk("flush", 32'(flush), 32'(last.redir));
                    after_res = 1'b1;
                    if (last.redir) begin
                        redir_exp = 1'b1;
                        redir_tgt = last.tgt;
                    end
                end
            end else begin
                chk("stray_pulse", 32'({flush, misalign, res_taken}), 32'd0);
            end
            if (redir_valid) begin
                if (!redir_exp) begin
                    bad("unexpected_redir_valid");
                end else begin
                    chk("redir_pc", redir_pc, redir_tgt);
                    chk("redir_stall", 32'(stall), 32'd1);
                    if (redir_ready) begin
                        redir_exp = 1'b0;
                        post = 0;
                    end
                end
            end else if (redir_exp && !res_valid) begin
                bad("redir_missing");
                redir_exp = 1'b0;
            end
        end
    end

    task automatic garbage();
        req_valid = 1'($urandom_range(0, 1));
        req_br_op = br_op_t'(3'($urandom_range(0, 6)));
        req_rs1   = $urandom;
        req_rs2   = $urandom;
        req_imm_b = $urandom;
        req_pc    = $urandom;
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake.
    task automatic issue(input br_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        int   n = 0;
        while (!req_ready) begin
            garbage();
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                bad("req_ready_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b1;
        req_br_op = op;
        req_rs1   = a;
        req_rs2   = b;
        req_imm_b = imm;
        req_pc    = pc;
        e.taken = cond(op, a, b);
        e.tgt   = pc + imm;
        e.mis   = e.taken && (e.tgt[1:0] != 2'b00);
        e.redir = e.taken && !e.mis;
        m_br++;
        if (e.taken) m_tk++;
        e.brc = m_br;
        e.tkc = m_tk;
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, imm, pc;
        int          n;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_during", 32'(req_ready), 32'd1);
        chk("rst_redir_during", 32'({redir_valid, stall, flush, res_valid}), 32'd0);
        rst_n = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_bru_op", 32'(bru_op), 32'(BR_NONE));
        chk("rst_pulses", 32'({redir_valid, stall, flush, res_valid, res_taken, misalign}), 32'd0);
        chk("rst_br_count", br_count, 32'd0);
        chk("rst_taken_count", taken_count, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_bru_ops", bru_rs1 | bru_rs2 | bru_imm_b | bru_pc, 32'd0);

        hold_lo = 0;
        issue(BR_BEQ, 32'd5, 32'd5, 32'h40, 32'h100);
        cycles(6);
        issue(BR_BNE, 32'd7, 32'd7, 32'h40, 32'h180);
        cycles(2);
        issue(BR_BEQ, 32'd3, 32'd3, 32'h6, 32'h200);
        cycles(2);
        hold_lo = 5;
        issue(BR_BLTU, 32'd1, 32'd9, 32'h80, 32'h400);
        cycles(12);

        for (int i = 0; i < 150; i++) begin
            a   = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            b   = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            imm = ($urandom & 32'h0000_0FFC) |
                  (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            pc  = $urandom & 32'hFFFF_FFFC;
            hold_lo = $urandom_range(0, 4);
            issue(br_op_t'(3'($urandom_range(0, 6))), a, b, imm, pc);
            cycles($urandom_range(0, 2));
        end
        cycles(12);

        // Reset in the middle of a redirect.
        hold_lo = 20;
        issue(BR_BEQ, 32'd1, 32'd1, 32'h40, 32'h300);
        cycles(1);
        chk("pre_rst_redir", 32'(redir_valid), 32'd1);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        m_br = '0;
        m_tk = '0;
        chk("post_rst_redir", 32'({redir_valid, stall}), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_br_count", br_count, 32'd0);
        chk("post_rst_taken_count", taken_count, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycles(1);
            chk("post_rst_quiet", 32'({flush, res_valid, redir_valid}), 32'd0);
        end
        hold_lo = 0;

        // Counter wrap.
        force dut.br_count = 32'hFFFF_FFFF;
        #1;
        release dut.br_count;
        m_br = 32'hFFFF_FFFF;
        chk("preload_br_count", br_count, 32'hFFFF_FFFF);
        n = 0;
        issue(BR_BNE, 32'd7, 32'd7, 32'h10, 32'h500);
        cycles(3);
        chk("wrap_br_count", br_count, 32'd0);

        cycles(10);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
